// File: rtl/divider_8bit_if.sv
// Start/done handshake bundle for the sequential divider.
// master drives operands and start; slave returns status and results.
interface divider_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] num_1;
    logic [WIDTH-1:0] num_2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, num_1, num_2,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, num_1, num_2,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/divider_8bit.sv
// Sequential restoring divider: one trial subtraction per clock,
// quotient and remainder published with a one-cycle done pulse.
module divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    divider_8bit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH:0]   r_r;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dz;

    state_t           w_state_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic [WIDTH-1:0] w_d_nx;
    logic [WIDTH:0]   w_r_nx;
    logic [CW-1:0]    w_cnt_nx;
    logic [WIDTH-1:0] w_quot_nx;
    logic [WIDTH-1:0] w_rem_nx;
    logic             w_dz_nx;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;

    assign w_shift = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_d};

    always_comb begin
        w_state_nx = r_state;
        w_q_nx     = r_q;
        w_d_nx     = r_d;
        w_r_nx     = r_r;
        w_cnt_nx   = r_cnt;
        w_quot_nx  = r_quot;
        w_rem_nx   = r_rem;
        w_dz_nx    = r_dz;
        case (r_state)
            S_CALC: begin
                w_q_nx   = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
                w_r_nx   = w_trial[WIDTH] ? w_shift : w_trial;
                w_cnt_nx = r_cnt + 1'b1;
                // Results load on the final iteration so they align with done.
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_nx = S_DONE;
                    w_quot_nx  = w_q_nx;
                    w_rem_nx   = w_r_nx[WIDTH-1:0];
                    w_dz_nx    = 1'b0;
                end
            end
            default: begin
                if (bus.start) begin
                    w_q_nx   = bus.num_1;
                    w_d_nx   = bus.num_2;
                    w_r_nx   = '0;
                    w_cnt_nx = '0;
                    if (bus.num_2 == '0) begin
                        w_state_nx = S_DONE;
                        w_quot_nx  = '1;
                        w_rem_nx   = bus.num_1;
                        w_dz_nx    = 1'b1;
                    end else begin
                        w_state_nx = S_CALC;
                    end
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_d     <= '0;
            r_r     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_q     <= w_q_nx;
            r_d     <= w_d_nx;
            r_r     <= w_r_nx;
            r_cnt   <= w_cnt_nx;
            r_busy  <= (w_state_nx == S_CALC);
            r_done  <= (w_state_nx == S_DONE);
            r_quot  <= w_quot_nx;
            r_rem   <= w_rem_nx;
            r_dz    <= w_dz_nx;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.div_zero  = r_dz;
endmodule

// File: tb/tb_divider_8bit.sv
// Directed and random checks of divider_8bit: reset, results,
// latency, divide by zero, ignored start, back-to-back, mid-run reset.
module tb_divider_8bit;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    divider_8bit_if #(.WIDTH(8)) bus ();

    divider_8bit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        bus.start = 1'b1;
        bus.num_1 = a;
        bus.num_2 = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.num_1 = 8'hxx;
        bus.num_2 = 8'hxx;
    endtask

    // Watches 12 cycles after the accept edge; lat counts start cycle as 1.
    task automatic measure(output int lat, output int nbusy,
                           output int ndone, output logic [7:0] q,
                           output logic [7:0] r, output logic dz,
                           output int nover);
        lat = 0; nbusy = 0; ndone = 0; nover = 0;
        q = 8'h00; r = 8'h00; dz = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus.busy) nbusy++;
            if (bus.busy && bus.done) nover++;
            if (bus.done) begin
                if (ndone == 0) begin
                    lat = k + 1;
                    q   = bus.quotient;
                    r   = bus.remainder;
                    dz  = bus.div_zero;
                end
                ndone++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int lat, nb, nd, no;
        logic [7:0] q, r;
        logic dz;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder,
             bus.div_zero} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_sync: busy=%b done=%b q=%h r=%h dz=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder,
                     bus.div_zero);
        end
        start_op(8'd200, 8'd7);
        measure(lat, nb, nd, q, r, dz, no);
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder,
             bus.div_zero} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_async: busy=%b done=%b q=%h r=%h dz=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder,
                     bus.div_zero);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [7:0] va [4] = '{8'd200, 8'd255, 8'd5, 8'd0};
        logic [7:0] vb [4] = '{8'd7, 8'd1, 8'd9, 8'd3};
        logic [7:0] eq [4] = '{8'd28, 8'd255, 8'd0, 8'd0};
        logic [7:0] er [4] = '{8'd4, 8'd0, 8'd5, 8'd0};
        int lat, nb, nd, no;
        logic [7:0] q, r;
        logic dz;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i]);
            measure(lat, nb, nd, q, r, dz, no);
            n_vec++;
            if (q !== eq[i] || r !== er[i] || dz !== 1'b0) begin
                n_err++;
                $display("FAIL basic_%0d/%0d: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=0",
                         va[i], vb[i], q, r, dz, eq[i], er[i]);
            end
            n_vec++;
            if (lat !== 9 || nd !== 1 || nb !== 8 || no !== 0) begin
                n_err++;
                $display("FAIL basic_timing_%0d: lat=%0d done=%0d busy=%0d ovl=%0d want 9/1/8/0",
                         i, lat, nd, nb, no);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, nb, nd, no;
        logic [7:0] q, r;
        logic dz;
        start_op(8'd100, 8'd0);
        measure(lat, nb, nd, q, r, dz, no);
        n_vec++;
        if (q !== 8'hFF || r !== 8'h64 || dz !== 1'b1) begin
            n_err++;
            $display("FAIL div_zero: got q=%h r=%h dz=%b want q=ff r=64 dz=1",
                     q, r, dz);
        end
        n_vec++;
        if (lat !== 1 || nb !== 0 || nd !== 1) begin
            n_err++;
            $display("FAIL div_zero_timing: lat=%0d busy=%0d done=%0d want 1/0/1",
                     lat, nb, nd);
        end
        start_op(8'd9, 8'd3);
        measure(lat, nb, nd, q, r, dz, no);
        n_vec++;
        if (q !== 8'd3 || r !== 8'd0 || dz !== 1'b0 || lat !== 9) begin
            n_err++;
            $display("FAIL after_zero: got q=%0d r=%0d dz=%b lat=%0d want 3 0 0 9",
                     q, r, dz, lat);
        end
    endtask

    task automatic test_start_while_busy();
        int nd;
        logic [7:0] q, r;
        nd = 0; q = 8'h00; r = 8'h00;
        start_op(8'd200, 8'd7);
        repeat (2) @(posedge clk);
        #1;
        start_op(8'd10, 8'd2);
        for (int k = 0; k < 25; k++) begin
            if (bus.done) begin
                if (nd == 0) begin
                    q = bus.quotient;
                    r = bus.remainder;
                end
                nd++;
            end
            @(posedge clk);
            #1;
        end
        n_vec++;
        if (q !== 8'd28 || r !== 8'd4 || nd !== 1) begin
            n_err++;
            $display("FAIL start_busy: got q=%0d r=%0d dones=%0d want 28 4 1",
                     q, r, nd);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nb, nd, no, k;
        logic [7:0] q1, r1, q, r;
        logic dz;
        q1 = 8'h00; r1 = 8'h00;
        start_op(8'd50, 8'd6);
        k = 0;
        while (!bus.done && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (bus.done) begin
            q1 = bus.quotient;
            r1 = bus.remainder;
        end
        start_op(8'd77, 8'd8);
        n_vec++;
        if (q1 !== 8'd8 || r1 !== 8'd2 || k !== 8) begin
            n_err++;
            $display("FAIL b2b_first: got q=%0d r=%0d wait=%0d want 8 2 8",
                     q1, r1, k);
        end
        measure(lat, nb, nd, q, r, dz, no);
        n_vec++;
        if (q !== 8'd9 || r !== 8'd5 || lat !== 9 || nd !== 1) begin
            n_err++;
            $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d done=%0d want 9 5 9 1",
                     q, r, lat, nd);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nb, nd, no;
        logic [7:0] q, r;
        logic dz;
        start_op(8'd200, 8'd7);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder,
             bus.div_zero} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_mid: busy=%b done=%b q=%h r=%h dz=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder,
                     bus.div_zero);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        measure(lat, nb, nd, q, r, dz, no);
        n_vec++;
        if (nd !== 0 || nb !== 0) begin
            n_err++;
            $display("FAIL reset_mid_quiet: done=%0d busy=%0d want 0 0", nd, nb);
        end
        start_op(8'd255, 8'd16);
        measure(lat, nb, nd, q, r, dz, no);
        n_vec++;
        if (q !== 8'd15 || r !== 8'd15 || dz !== 1'b0 || lat !== 9) begin
            n_err++;
            $display("FAIL after_reset: got q=%0d r=%0d dz=%b lat=%0d want 15 15 0 9",
                     q, r, dz, lat);
        end
    endtask

    task automatic test_random();
        int lat, nb, nd, no, elat;
        logic [7:0] a, b, q, r, eq, er;
        logic dz, edz;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) b = 8'd0;
            if (b == 8'd0) begin
                eq = 8'hFF; er = a; edz = 1'b1; elat = 1;
            end else begin
                eq = a / b; er = a % b; edz = 1'b0; elat = 9;
            end
            start_op(a, b);
            measure(lat, nb, nd, q, r, dz, no);
            n_vec++;
            if (q !== eq || r !== er || dz !== edz || lat !== elat
                || nd !== 1 || no !== 0) begin
                n_err++;
                $display("FAIL rand_%0d/%0d: got q=%0d r=%0d dz=%b lat=%0d want %0d %0d %b %0d",
                         a, b, q, r, dz, lat, eq, er, edz, elat);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.num_1 = 8'h00;
        bus.num_2 = 8'h00;
        test_reset();
        test_basic();
        test_div_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
